// File: rtl/fp_adder_pipelined.sv
// 3-stage pipelined IEEE-754 adder/subtractor: S1 unpack/align, S2 add/normalize, S3 round/pack.
// Flush-to-zero on denormal inputs and on underflowing results; round to nearest, ties to even.
module fp_adder_pipelined #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid,
    output logic         inexact,
    output logic [3:0]   flags_sticky
);
    localparam int SW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int ESW = EXP_W + 2;          // room for exponent carry and negative excursion
    localparam int LZW = $clog2(SW + 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        lzc = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) lzc = LZW'(SW - 1 - i);
    endfunction

    logic [3:1] vld_pipe, en;
    assign en[3]     = !vld_pipe[3] | out_ready;
    assign en[2]     = !vld_pipe[2] | en[3];
    assign en[1]     = !vld_pipe[1] | en[2];
    assign in_ready  = en[1];
    assign out_valid = vld_pipe[3];

    // ---------------- S1: unpack / swap / align ----------------
    logic             sa, sb, za, zb, a_inf, b_inf, a_nan, b_nan, swap, sl;
    logic [EXP_W-1:0] ea, eb, el, es, ediff;
    logic [MAN_W-1:0] fa, fb, fl, fs;
    logic             zs, c_spec, c_inv;
    logic [SW-1:0]    sig_l, sig_s, sig_al, ones;
    logic [W-1:0]     c_sres;

    always_comb begin
        sa    = op_a[W-1];
        sb    = op_b[W-1] ^ sub;
        ea    = op_a[W-2:MAN_W];
        eb    = op_b[W-2:MAN_W];
        za    = (ea == '0);
        zb    = (eb == '0);
        fa    = za ? '0 : op_a[MAN_W-1:0];
        fb    = zb ? '0 : op_b[MAN_W-1:0];
        a_inf = (&ea) && (fa == '0);
        b_inf = (&eb) && (fb == '0);
        a_nan = (&ea) && (fa != '0);
        b_nan = (&eb) && (fb != '0);
        swap  = {eb, fb} > {ea, fa};
        el    = swap ? eb : ea;
        es    = swap ? ea : eb;
        fl    = swap ? fb : fa;
        fs    = swap ? fa : fb;
        sl    = swap ? sb : sa;
        zs    = swap ? za : zb;
        sig_l = {1'b1, fl, 3'b000};
        sig_s = {!zs, fs, 3'b000};
        ediff = el - es;
        ones  = '1;
        if (int'(ediff) >= SW - 1)
            sig_al = {{(SW-1){1'b0}}, |sig_s};
        else
            sig_al = (sig_s >> ediff) | {{(SW-1){1'b0}}, |(sig_s & ~(ones << ediff))};
        c_inv  = a_inf & b_inf & (sa ^ sb);
        c_spec = a_nan | b_nan | a_inf | b_inf | (za & zb);
        if (a_nan | b_nan | c_inv) c_sres = QNAN;
        else if (a_inf)            c_sres = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (b_inf)            c_sres = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else                       c_sres = {sa & sb, {(W-1){1'b0}}};
    end

    logic             s1_spec, s1_inv, s1_sign, s1_esub;
    logic [W-1:0]     s1_sres;
    logic [EXP_W-1:0] s1_exp;
    logic [SW-1:0]    s1_siga, s1_sigb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            s1_spec <= 1'b0; s1_inv <= 1'b0; s1_sign <= 1'b0; s1_esub <= 1'b0;
            s1_sres <= '0;   s1_exp <= '0;   s1_siga <= '0;   s1_sigb <= '0;
        end else if (en[1]) begin
            vld_pipe[1] <= in_valid;
            s1_spec <= c_spec; s1_inv <= c_inv; s1_sign <= sl; s1_esub <= sa ^ sb;
            s1_sres <= c_sres; s1_exp <= el;    s1_siga <= sig_l; s1_sigb <= sig_al;
        end
    end

    // ---------------- S2: add / normalize ----------------
    logic [SW:0]      sum;
    logic [LZW-1:0]   lz;
    logic [SW-1:0]    nsig;
    logic [ESW-1:0]   nexp;

    always_comb begin
        sum = s1_esub ? ({1'b0, s1_siga} - {1'b0, s1_sigb})
                      : ({1'b0, s1_siga} + {1'b0, s1_sigb});
        lz  = lzc(sum[SW-1:0]);
        if (sum[SW]) begin
            nsig = {sum[SW:2], sum[1] | sum[0]};
            nexp = {2'b00, s1_exp} + ESW'(1);
        end else begin
            nsig = sum[SW-1:0] << lz;
            nexp = {2'b00, s1_exp} - ESW'(lz);
        end
    end

    logic             s2_spec, s2_inv, s2_sign, s2_zero;
    logic [W-1:0]     s2_sres;
    logic [ESW-1:0]   s2_exp;
    logic [SW-1:0]    s2_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[2] <= 1'b0;
            s2_spec <= 1'b0; s2_inv <= 1'b0; s2_sign <= 1'b0; s2_zero <= 1'b0;
            s2_sres <= '0;   s2_exp <= '0;   s2_sig <= '0;
        end else if (en[2]) begin
            vld_pipe[2] <= vld_pipe[1];
            s2_spec <= s1_spec; s2_inv <= s1_inv; s2_sign <= s1_sign; s2_zero <= (sum == '0);
            s2_sres <= s1_sres; s2_exp <= nexp;   s2_sig <= nsig;
        end
    end

    // ---------------- S3: round / pack ----------------
    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] rnd;
    logic [ESW-1:0]   rexp;
    logic [MAN_W-1:0] rfrac;
    logic             grs;
    logic [W-1:0]     n_res;
    logic             n_ovf, n_unf, n_inv, n_inx;

    always_comb begin
        mant  = s2_sig[SW-1:3];
        grs   = |s2_sig[2:0];
        rnd   = {1'b0, mant} + (MAN_W+2)'(s2_sig[2] & (s2_sig[1] | s2_sig[0] | mant[0]));
        rexp  = s2_exp + ESW'(rnd[MAN_W+1]);
        rfrac = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        n_res = {s2_sign, rexp[EXP_W-1:0], rfrac};
        n_ovf = 1'b0; n_unf = 1'b0; n_inv = 1'b0; n_inx = grs;
        if (s2_spec) begin
            n_res = s2_sres;
            n_inv = s2_inv;
            n_inx = 1'b0;
        end else if (s2_zero) begin
            n_res = '0;
            n_inx = 1'b0;
        end else if (!rexp[ESW-1] && rexp[ESW-2:0] >= (ESW-1)'((1 << EXP_W) - 1)) begin
            n_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            n_ovf = 1'b1;
            n_inx = 1'b1;
        end else if (rexp[ESW-1] || rexp == '0) begin
            n_res = {s2_sign, {(W-1){1'b0}}};
            n_unf = 1'b1;
            n_inx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[3] <= 1'b0;
            result <= '0; overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0; inexact <= 1'b0;
        end else if (en[3]) begin
            vld_pipe[3] <= vld_pipe[2];
            result <= n_res; overflow <= n_ovf; underflow <= n_unf; invalid <= n_inv; inexact <= n_inx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags_sticky <= '0;
        else if (vld_pipe[3] && out_ready)
            flags_sticky <= flags_sticky | {overflow, underflow, invalid, inexact};
    end
endmodule

// File: tb/tb_fp_adder_pipelined.sv
// Directed bench for fp_adder_pipelined (single precision): latency, arithmetic,
// rounding, specials, back-pressure streaming and mid-flight reset.
module tb_fp_adder_pipelined;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         in_ready, out_valid, overflow, underflow, invalid, inexact;
    logic [W-1:0] result;
    logic [3:0]   flags_sticky, fl;

    int total = 0;
    int bad   = 0;

    fp_adder_pipelined dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow), .invalid(invalid),
        .inexact(inexact), .flags_sticky(flags_sticky)
    );

    assign fl = {overflow, underflow, invalid, inexact};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the accepting posedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bit ok = 1'b0;
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #2 ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) chk("issue_timeout", W'(ok), W'(1));
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [W-1:0] er, input logic [3:0] ef);
        issue(a, b, s);
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        chk({tag, "_valid"}, W'(out_valid), W'(1));
        chk({tag, "_res"}, result, er);
        chk({tag, "_flags"}, W'(fl), W'(ef));
        @(negedge clk);
    endtask

    logic [W-1:0] stream_a [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                   32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [W-1:0] stream_e [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                                   32'h40A00000, 32'h40C00000, 32'h40E00000};
    logic [W-1:0] got [6];

    initial begin
        int  n = 0;
        bit  stalled = 1'b0, saw_block = 1'b0;
        logic [W-1:0] held_res = '0;
        logic [3:0]   held_fl  = '0;

        // Reset state
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_result", result, W'(0));
        chk("rst_flags", W'(fl), W'(0));
        chk("rst_sticky", W'(flags_sticky), W'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", W'(in_ready), W'(1));
        @(negedge clk);

        // Latency: out_valid appears in the third cycle after the accepting cycle
        issue(32'h3F800000, 32'h3F800000, 1'b0);
        chk("lat_c1", W'(out_valid), W'(0));
        @(negedge clk);
        chk("lat_c2", W'(out_valid), W'(0));
        @(negedge clk);
        chk("lat_c3", W'(out_valid), W'(1));
        chk("lat_res", result, 32'h40000000);
        chk("lat_flags", W'(fl), W'(0));
        @(negedge clk);

        run_one("sub_mixed",  32'h3FC00000, 32'h3F000000, 1'b1, 32'h3F800000, 4'b0000);
        run_one("cancel",     32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 4'b0000);
        run_one("tie_even0",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        run_one("tie_up",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        run_one("x_plus_0",   32'h40400000, 32'h00000000, 1'b0, 32'h40400000, 4'b0000);
        run_one("negz_negz",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        run_one("posz_negz",  32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
        run_one("inf_fin",    32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
        run_one("nan_in",     32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
        run_one("inf_m_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b0010);
        run_one("ovf",        32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1001);
        run_one("unf",        32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0101);
        chk("sticky_all", W'(flags_sticky), W'(4'b1111));

        // Back-pressure streaming: out_ready follows 1,0,0,1,0,0,...
        fork
            begin
                for (int i = 0; i < 6; i++) issue(stream_a[i], 32'h3F800000, 1'b0);
            end
            begin
                for (int c = 0; c < 80 && n < 6; c++) begin
                    @(negedge clk);
                    out_ready = (c % 3 == 0);
                    #1;
                    if (stalled) begin
                        chk("stall_res", result, held_res);
                        chk("stall_flags", W'(fl), W'(held_fl));
                    end
                    if (out_ready) chk("ready_when_drain", W'(in_ready), W'(1));
                    if (!in_ready) saw_block = 1'b1;
                    if (out_valid && out_ready) begin
                        got[n] = result;
                        n++;
                    end
                    stalled  = out_valid && !out_ready;
                    held_res = result;
                    held_fl  = fl;
                end
            end
        join
        out_ready = 1'b1;
        chk("stream_count", W'(n), W'(6));
        for (int i = 0; i < 6; i++) chk($sformatf("stream_%0d", i), got[i], stream_e[i]);
        chk("stream_blocked", W'(saw_block), W'(1));
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("stream_no_dup", W'(out_valid), W'(0));

        // Reset with three operations in flight
        issue(32'h3F800000, 32'h3F800000, 1'b0);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        issue(32'h40000000, 32'h40000000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", W'(out_valid), W'(0));
        chk("mrst_sticky", W'(flags_sticky), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mrst_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        issue(32'h40000000, 32'h3F800000, 1'b0);
        chk("mrst_c1", W'(out_valid), W'(0));
        @(negedge clk);
        chk("mrst_c2", W'(out_valid), W'(0));
        @(negedge clk);
        chk("mrst_c3", W'(out_valid), W'(1));
        chk("mrst_res", result, 32'h40400000);
        @(negedge clk);
        chk("mrst_alone", W'(out_valid), W'(0));
        chk("mrst_sticky_end", W'(flags_sticky), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
